// File: rtl/sync_debounce_edge_pkg.sv
// Shared constants for the debounce/edge-detect block.
// Edge-select bit positions and the default stability counter width.
package sync_debounce_edge_pkg;
    localparam int EDGE_RISE         = 0;
    localparam int EDGE_FALL         = 1;
    localparam int CNT_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/sync_debounce_edge_cell.sv
// One filtered bit: stability counter, level flop, edge pulses and sticky event flag.
module debounce_cell
    import sync_debounce_edge_pkg::*;
#(
    parameter int   CNT_WIDTH = CNT_WIDTH_DEFAULT,
    parameter logic INIT_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic [CNT_WIDTH-1:0] cfg_stable_cnt,
    input  logic [1:0]           cfg_edge_sel,
    input  logic                 evt_clr,
    output logic                 dout,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 evt_sticky
);
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_dout;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_sticky;

    logic w_mismatch;
    logic w_commit;
    logic w_rise_next;
    logic w_fall_next;
    logic w_set;

    assign w_mismatch  = (din != r_dout);
    // >= so that lowering the window mid-count commits immediately instead of wrapping
    assign w_commit    = w_mismatch && (r_cnt >= cfg_stable_cnt);
    assign w_rise_next = w_commit & din;
    assign w_fall_next = w_commit & ~din;
    assign w_set       = (w_rise_next & cfg_edge_sel[EDGE_RISE]) |
                         (w_fall_next & cfg_edge_sel[EDGE_FALL]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dout   <= INIT_BIT;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            if (!w_mismatch || w_commit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            if (w_commit) begin
                r_dout <= din;
            end
            r_rise   <= w_rise_next;
            r_fall   <= w_fall_next;
            r_sticky <= w_set | (r_sticky & ~evt_clr);
        end
    end

    assign dout       = r_dout;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign evt_sticky = r_sticky;
endmodule

// File: rtl/sync_debounce_edge.sv
// Multi-bit glitch filter with edge pulses, sticky events and an aggregated interrupt.
module sync_debounce_edge
    import sync_debounce_edge_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    CNT_WIDTH  = CNT_WIDTH_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [CNT_WIDTH-1:0]  cfg_stable_cnt,
    input  logic [1:0]            cfg_edge_sel,
    input  logic [DATA_WIDTH-1:0] evt_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] rise_pulse,
    output logic [DATA_WIDTH-1:0] fall_pulse,
    output logic [DATA_WIDTH-1:0] evt_sticky,
    output logic                  irq
);
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
        debounce_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .INIT_BIT  (INIT_VALUE[g])
        ) u_cell (
            .clk            (clk),
            .rst            (rst),
            .din            (din[g]),
            .cfg_stable_cnt (cfg_stable_cnt),
            .cfg_edge_sel   (cfg_edge_sel),
            .evt_clr        (evt_clr[g]),
            .dout           (dout[g]),
            .rise_pulse     (rise_pulse[g]),
            .fall_pulse     (fall_pulse[g]),
            .evt_sticky     (evt_sticky[g])
        );
    end

    // Built only from sticky flops, so irq cannot glitch
    assign irq = |evt_sticky;
endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed-vector bench for sync_debounce_edge with hand-computed expectations.
module tb_sync_debounce_edge;
    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [7:0]  cfg_stable_cnt;
    logic [1:0]  cfg_edge_sel;
    logic [15:0] evt_clr;
    logic [15:0] dout;
    logic [15:0] rise_pulse;
    logic [15:0] fall_pulse;
    logic [15:0] evt_sticky;
    logic        irq;

    int n_vec;
    int n_err;

    sync_debounce_edge #(
        .DATA_WIDTH (16),
        .CNT_WIDTH  (8),
        .INIT_VALUE (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .din            (din),
        .cfg_stable_cnt (cfg_stable_cnt),
        .cfg_edge_sel   (cfg_edge_sel),
        .evt_clr        (evt_clr),
        .dout           (dout),
        .rise_pulse     (rise_pulse),
        .fall_pulse     (fall_pulse),
        .evt_sticky     (evt_sticky),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        din            = 16'hFFFF;
        cfg_stable_cnt = 8'd3;
        cfg_edge_sel   = 2'b01;
        evt_clr        = 16'h0000;

        step(3);
        check_vec("rst_dout", dout, 16'h0000);
        check_vec("rst_rise", rise_pulse, 16'h0000);
        check_vec("rst_fall", fall_pulse, 16'h0000);
        check_vec("rst_sticky", evt_sticky, 16'h0000);
        check_vec("rst_irq", irq, 1'b0);

        din = 16'h0000;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            check_vec("post_rst_pulses", rise_pulse | fall_pulse, 16'h0000);
        end

        // threshold timing, cfg=3: commit on the 4th sampling edge
        din[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step(1);
            check_vec("thr_hold_dout0", dout[0], 1'b0);
        end
        step(1);
        check_vec("thr_dout0", dout[0], 1'b1);
        check_vec("thr_rise0", rise_pulse[0], 1'b1);
        check_vec("thr_sticky0", evt_sticky[0], 1'b1);
        check_vec("thr_irq", irq, 1'b1);
        step(1);
        check_vec("thr_rise0_gone", rise_pulse[0], 1'b0);
        check_vec("thr_dout0_kept", dout[0], 1'b1);

        evt_clr = 16'h0001;
        step(1);
        evt_clr = 16'h0000;
        check_vec("clr0_sticky", evt_sticky, 16'h0000);
        check_vec("clr0_irq", irq, 1'b0);

        // glitch of exactly cfg edges is rejected
        din[5] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check_vec("glitch_hi", {dout[5], rise_pulse[5], fall_pulse[5], evt_sticky[5]}, 4'b0000);
        end
        din[5] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check_vec("glitch_lo", {dout[5], rise_pulse[5], fall_pulse[5], evt_sticky[5]}, 4'b0000);
        end

        // edge select: fall-only capture, cfg=0
        cfg_stable_cnt = 8'd0;
        cfg_edge_sel   = 2'b10;
        din[2]         = 1'b1;
        step(1);
        check_vec("sel_rise2", {dout[2], rise_pulse[2], fall_pulse[2]}, 3'b110);
        check_vec("sel_rise_nosticky", evt_sticky[2], 1'b0);
        check_vec("sel_rise_irq", irq, 1'b0);
        step(4);
        check_vec("sel_rise2_gone", rise_pulse[2], 1'b0);
        din[2] = 1'b0;
        step(1);
        check_vec("sel_fall2", {dout[2], rise_pulse[2], fall_pulse[2]}, 3'b001);
        check_vec("sel_fall_sticky", evt_sticky[2], 1'b1);
        check_vec("sel_fall_irq", irq, 1'b1);
        step(4);
        check_vec("sel_fall2_gone", fall_pulse[2], 1'b0);
        check_vec("sel_sticky_hold", evt_sticky[2], 1'b1);

        // clear collides with a new fall: set wins
        din[2] = 1'b1;
        step(5);
        din[2]  = 1'b0;
        evt_clr = 16'h0004;
        step(1);
        evt_clr = 16'h0000;
        check_vec("coll_fall2", fall_pulse[2], 1'b1);
        check_vec("coll_sticky2", evt_sticky[2], 1'b1);
        step(1);
        evt_clr = 16'h0004;
        step(1);
        evt_clr = 16'h0000;
        check_vec("late_clr_sticky2", evt_sticky[2], 1'b0);
        check_vec("late_clr_irq", irq, 1'b0);

        // lowering the window mid-count commits on the next mismatching edge
        cfg_stable_cnt = 8'd200;
        din[7]         = 1'b1;
        step(100);
        check_vec("mid_hold_dout7", dout[7], 1'b0);
        cfg_stable_cnt = 8'd10;
        step(1);
        check_vec("mid_dout7", dout[7], 1'b1);
        check_vec("mid_rise7", rise_pulse[7], 1'b1);
        check_vec("mid_nosticky7", evt_sticky[7], 1'b0);

        // reset mid-count discards the partial count
        cfg_stable_cnt = 8'd200;
        din            = 16'h0200;
        step(50);
        rst = 1'b1;
        #1;
        check_vec("midrst_dout", dout, 16'h0000);
        check_vec("midrst_pulses", rise_pulse | fall_pulse, 16'h0000);
        step(1);
        rst = 1'b0;
        step(200);
        check_vec("restart_hold_dout9", dout[9], 1'b0);
        step(1);
        check_vec("restart_dout", dout, 16'h0200);
        check_vec("restart_rise9", rise_pulse, 16'h0200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
